uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receive engine of the UART path. Oversamples the asynchronous rx pin with the system clock.
//  Frames 8N1 / 8O1 / 8E1 characters and emits one-cycle byte strobes with data and an error strobe.
//  Sits directly upstream of the DI-side RX FIFO: re/rx_data/rx_error/rx_busy drive it unmodified.
// PARAMETERS
//  CLK_DIV_WIDTH  16  width of clk_div; bit period counter width
// PORTS
//  clk          in   1              system clock (all logic single-clock)
//  resetb       in   1              async active-low reset
//  clk_div      in   CLK_DIV_WIDTH  clk cycles per bit; legal range >= 8
//  parity_mode  in   2              0 none, 1 odd, 2 even, 3 treated as none
//  rx           in   1              async serial input, idle high
//  re           out  1              1-cycle strobe: rx_data holds a new good byte
//  rx_data      out  8              last good byte, LSB received first
//  rx_error     out  1              1-cycle strobe: parity or framing error
//  rx_busy      out  1              high from start detect until frame end/abort
// BEHAVIOUR
//  Reset values: re=0, rx_error=0, rx_busy=0, rx_data=8'h00, sync flops=1, state=IDLE.
//  Reset is async active-low; a mid-frame reset discards the partial byte with no strobe.
//  Input: 2-flop synchroniser (reset to 1). Start = falling edge of synced rx, seen in IDLE only.
//  Line held low (break) never retriggers; a new frame needs a high-to-low edge.
//  clk_div and parity_mode are latched at start detect; changes mid-frame take effect next frame.
//  Bit counter loads latched div-1 and counts down; sample point = mid-bit (div>>1 elapsed).
//  FSM:
//   IDLE   -> START on edge; rx_busy=1 from the next cycle.
//   START  at mid-bit: sample 1 -> IDLE (false start, no strobes); sample 0 -> DATA.
//   DATA   8 samples, one per bit period, shifted in LSB first -> PARITY if mode 1/2, else STOP.
//   PARITY one sample. Odd: XOR(data, p) must be 1. Even: XOR(data, p) must be 0.
//   STOP   at mid-bit -> IDLE immediately (half a bit early, so back-to-back frames are caught).
//          Good = stop==1 && parity ok.
//          Good: re=1 and rx_data updated in the cycle after the sample.
//          Bad: rx_error=1 in that same cycle; no re; rx_data unchanged.
//  re and rx_error are mutually exclusive and never high two cycles in a row.
//  rx_busy falls in the same cycle as the re/rx_error pulse, or the cycle after a false start.
//  Latency: rx pin edge to strobe = 2 sync + (9 or 10)*div + div/2 + 1 cycles.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//   each sample point takes 3 synced samples at mid-1, mid, mid+1; the bit is the 2-of-3 majority.
//   Strobe latency grows by 1 cycle.
//  Undefined: single sample at mid. Ports and FSM are identical either way.
// STRUCTURE
//  Package uart_pkg: FSM state enum (IDLE/START/DATA/PARITY/STOP) and PARITY_NONE/ODD/EVEN constants.
//   uart_pkg is shared with the TX engine.
//  Sub-module uart_sync: 2-flop reset-to-1 synchroniser, reused by other async inputs.
//  All other logic inline: counter, bit index, shift register, parity accumulator.
// TESTING  (clk_div=16 unless stated)
//  0xA5, parity none, good stop -> exactly one re; rx_data=8'hA5; rx_error never high.
//  0x03, even parity, parity bit=1 -> one rx_error; no re; rx_data keeps its previous value.
//  0x55 with stop bit=0 -> rx_error pulse; then hold rx low 40 bits -> no further strobes.
//  rx low for 4 cycles only -> false start: no re/rx_error; rx_busy drops about 9 cycles after the edge.
//  Back-to-back 0x00 then 0xFF, no idle gap, clk_div=8 -> two re pulses with data 00 then FF.
//  resetb low mid-DATA -> outputs at reset values at once; next clean frame 0x3C received correctly.
//  MAJORITY_EN: 1-cycle low glitch at the mid sample of a '1' data bit.
//   Macro defined: byte is correct. Macro undefined: that bit reads 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants, used by the RX and TX
// engines.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_ODD  = 2'd1;
   localparam logic [1:0] PARITY_EVEN = 2'd2;

   // Mode 3 is reserved and behaves as no parity.
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
   endfunction

   // acc is the XOR of the data bits and the received parity bit.
   function automatic logic parity_error(input logic [1:0] mode, input logic acc);
      return (mode == PARITY_ODD) ? ~acc : acc;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous inputs whose idle level is high; both flops reset to 1.
module uart_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: oversampled 8-bit frames with optional odd/even parity and one stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each sample point.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic [CLK_DIV_WIDTH-1:0] clk_div,
   input  logic [1:0]               parity_mode,
   input  logic                     rx,
   output logic                     re,
   output logic [7:0]               rx_data,
   output logic                     rx_error,
   output logic                     rx_busy
);

   localparam logic [CLK_DIV_WIDTH-1:0] One = CLK_DIV_WIDTH'(1);

   logic                     rx_s;
   logic                     rx_prev_q;
   uart_state_e              state_q;
   logic [CLK_DIV_WIDTH-1:0] div_q;
   logic [CLK_DIV_WIDTH-1:0] cnt_q;
   logic [CLK_DIV_WIDTH-1:0] mid_cnt;
   logic [CLK_DIV_WIDTH-1:0] tick_cnt;
   logic [1:0]               mode_q;
   logic [2:0]               bit_idx_q;
   logic [7:0]               shift_q;
   logic                     par_q;
   logic                     par_err_q;
   logic                     re_q;
   logic                     err_q;
   logic                     busy_q;
   logic [7:0]               data_q;
   logic                     tick;
   logic                     samp;

   uart_sync u_sync (
      .clk_i  (clk),
      .rst_ni (resetb),
      .d_i    (rx),
      .q_o    (rx_s)
   );

   // Counter value reached once div>>1 cycles of the current bit period have elapsed.
   assign mid_cnt = div_q - One - (div_q >> 1);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   // Decide one cycle after mid, once the mid+1 sample is available.
   always_comb begin
      tick_cnt = mid_cnt - One;
      samp     = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
   end
`else
   always_comb begin
      tick_cnt = mid_cnt;
      samp     = rx_s;
   end
`endif

   assign tick = (cnt_q == tick_cnt);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rx_prev_q <= 1'b1;
         state_q   <= StIdle;
         div_q     <= '0;
         cnt_q     <= '0;
         mode_q    <= PARITY_NONE;
         bit_idx_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         par_err_q <= 1'b0;
         re_q      <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         data_q    <= '0;
      end else begin
         rx_prev_q <= rx_s;
         re_q      <= 1'b0;
         err_q     <= 1'b0;
         if (state_q != StIdle) begin
            cnt_q <= (cnt_q == '0) ? div_q - One : cnt_q - One;
         end
         unique case (state_q)
            StIdle: begin
               // Only a high-to-low transition starts a frame, so a held break never retriggers.
               if (rx_prev_q && !rx_s) begin
                  state_q <= StStart;
                  busy_q  <= 1'b1;
                  div_q   <= clk_div;
                  mode_q  <= parity_mode;
                  cnt_q   <= clk_div - One;
               end
            end
            StStart: begin
               if (tick) begin
                  if (samp) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q   <= StData;
                     bit_idx_q <= '0;
                     par_q     <= 1'b0;
                     par_err_q <= 1'b0;
                  end
               end
            end
            StData: begin
               if (tick) begin
                  shift_q   <= {samp, shift_q[7:1]};
                  par_q     <= par_q ^ samp;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= parity_enabled(mode_q) ? StParity : StStop;
                  end
               end
            end
            StParity: begin
               if (tick) begin
                  par_err_q <= parity_error(mode_q, par_q ^ samp);
                  state_q   <= StStop;
               end
            end
            StStop: begin
               // Leave at mid stop bit so an immediately following start edge is not missed.
               if (tick) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  if (samp && !par_err_q) begin
                     re_q   <= 1'b1;
                     data_q <= shift_q;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign re       = re_q;
   assign rx_error = err_q;
   assign rx_busy  = busy_q;
   assign rx_data  = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame driver pushes expected strobes, a monitor pops and checks.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic [15:0] clk_div = 16'd16;
   logic [1:0]  parity_mode = 2'd0;
   logic        rx = 1'b1;
   logic        re;
   logic [7:0]  rx_data;
   logic        rx_error;
   logic        rx_busy;

   uart_rx #(.CLK_DIV_WIDTH(16)) dut (
      .clk         (clk),
      .resetb      (resetb),
      .clk_div     (clk_div),
      .parity_mode (parity_mode),
      .rx          (rx),
      .re          (re),
      .rx_data     (rx_data),
      .rx_error    (rx_error),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          good;
      logic [7:0]  data;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [7:0]  model_data = 8'h00;
   bit          prev_strobe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!resetb) begin
         prev_strobe = 1'b0;
      end else begin
         if (re || rx_error) begin
            check("strobe_exclusive", {31'd0, re & rx_error}, 32'd0);
            check("strobe_not_consecutive", {31'd0, prev_strobe}, 32'd0);
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_strobe: got re=%0b rx_error=%0b, expected none", re,
                        rx_error);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("strobe_kind_re", {31'd0, re}, {31'd0, e.good});
               check("strobe_time", cyc, e.at);
               if (e.good) begin
                  check("rx_data_good", {24'd0, rx_data}, {24'd0, e.data});
                  model_data = e.data;
               end else begin
                  check("rx_data_held", {24'd0, rx_data}, {24'd0, model_data});
               end
            end
         end
         prev_strobe = re || rx_error;
      end
   end

   task automatic idle(input int n, input logic level);
      for (int i = 0; i < n; i++) begin
         rx = level;
         @(negedge clk);
      end
   endtask

   // Drives one frame starting at the current negedge. gbit >= 0 puts a one-cycle low glitch at
   // the mid sample of that data bit; abort_at >= 0 stops driving after that many cycles.
   task automatic send_frame(input logic [7:0] d, input int div, input logic [1:0] mode,
                             input bit flip_par, input bit stop, input int gbit,
                             input int abort_at);
      bit          bits[$];
      bit          par_on;
      bit          p;
      int          ones;
      int          ones_got;
      logic [7:0]  got;
      exp_t        e;
      par_on = (mode == 2'd1) || (mode == 2'd2);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      // Legal parity bit for the mode, optionally corrupted.
      p = (mode == 2'd1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      p = p ^ flip_par;
      got = d;
      if (gbit >= 0 && MAJ == 0) got[gbit] = 1'b0;
      ones_got = 0;
      for (int i = 0; i < 8; i++) ones_got += int'(got[i]);
      e.good = stop;
      if (mode == 2'd1) e.good = e.good && (((ones_got + int'(p)) % 2) == 1);
      if (mode == 2'd2) e.good = e.good && (((ones_got + int'(p)) % 2) == 0);
      e.data = got;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (par_on) bits.push_back(p);
      bits.push_back(stop);
      // Pin edge to strobe: 2 sync + N*div + div/2 + 1 (+1 with majority); the first low level
      // is captured on the posedge after this negedge, hence the extra 1.
      e.at = cyc + 1 + 2 + (bits.size() - 1) * div + div / 2 + 1 + MAJ;
      clk_div = 16'(div);
      parity_mode = mode;
      if (abort_at < 0) sb.push_back(e);
      for (int j = 0; j < bits.size(); j++) begin
         for (int k = 0; k < div; k++) begin
            if (abort_at >= 0 && j * div + k == abort_at) return;
            rx = bits[j];
            if (gbit >= 0 && j == gbit + 1 && k == div / 2 + 1) rx = 1'b0;
            // Config inputs already latched; scramble them to prove the latch.
            if (j == 0 && k == 4) begin
               clk_div = 16'($urandom_range(8, 40));
               parity_mode = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      int unsigned c0;
      int          rise;
      int          fall;
      int          div;
      bit          stop;

      resetb = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_re", {31'd0, re}, 32'd0);
      check("reset_rx_error", {31'd0, rx_error}, 32'd0);
      check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      resetb = 1'b1;
      idle(4, 1'b1);

      send_frame(8'hA5, 16, 2'd0, 1'b0, 1'b1, -1, -1);
      idle(20, 1'b1);
      send_frame(8'h03, 16, 2'd2, 1'b1, 1'b1, -1, -1);
      idle(20, 1'b1);
      send_frame(8'h55, 16, 2'd0, 1'b0, 1'b0, -1, -1);
      idle(40 * 16, 1'b0);
      idle(32, 1'b1);

      // False start: low for 4 cycles only.
      clk_div = 16'd16;
      parity_mode = 2'd0;
      c0 = cyc;
      rise = -1;
      fall = -1;
      for (int k = 0; k < 100; k++) begin
         rx = (k < 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (rx_busy && rise < 0) rise = int'(cyc - c0);
         if (!rx_busy && rise >= 0 && fall < 0) fall = int'(cyc - c0);
      end
      check("false_start_busy_rise", rise, 3);
      check("false_start_busy_fall", fall, 3 + 16 / 2 + 1 + MAJ);

      send_frame(8'h00, 8, 2'd0, 1'b0, 1'b1, -1, -1);
      send_frame(8'hFF, 8, 2'd0, 1'b0, 1'b1, -1, -1);
      idle(20, 1'b1);

      send_frame(8'hA5, 16, 2'd0, 1'b0, 1'b1, 0, -1);
      idle(20, 1'b1);

      // Reset in the middle of data bit 3.
      send_frame(8'h99, 16, 2'd0, 1'b0, 1'b1, -1, 16 * 4 + 3);
      check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
      resetb = 1'b0;
      rx = 1'b1;
      #1;
      check("midreset_re", {31'd0, re}, 32'd0);
      check("midreset_rx_error", {31'd0, rx_error}, 32'd0);
      check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
      check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      model_data = 8'h00;
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      idle(5, 1'b1);
      send_frame(8'h3C, 16, 2'd0, 1'b0, 1'b1, -1, -1);
      idle(20, 1'b1);

      for (int n = 0; n < 25; n++) begin
         div = int'($urandom_range(8, 24));
         stop = ($urandom_range(0, 6) != 0);
         send_frame(8'($urandom), div, 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                    stop, -1, -1);
         if (!stop) idle(div + int'($urandom_range(0, 5)), 1'b1);
         else if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 20)), 1'b1);
      end
      idle(10, 1'b1);

      for (int k = 0; k < 3000 && sb.size() > 0; k++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
